sw_tail_collector: RTL and testbench

Downstream stage of the PE array chain: consumes the per-cycle outputs of the last PE (boundary column `t`, `v`, `v_alpha`, `f`, `newLine`) plus the array's combinational `result`. It tracks the global best local-alignment score with its beat index. It buffers the tail boundary column in a FIFO so it can be re-injected at the array head on the next pass, when the query is longer than the array.

---
 rtl/sw_tail_collector_if.sv | 38 +++
 rtl/sw_tail_collector.sv | 148 ++++++++++++++
 tb/tb_sw_tail_collector.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_tail_collector_if.sv
// Tail-beat bus between the last PE and the collector, plus the recirculation
// FIFO read port that feeds the array head on the next pass.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

interface sw_tail_collector_if #(
  parameter int VW = `V_E_F_Bit
);
  logic          in_valid;
  logic          in_newLine;
  logic [1:0]    in_t;
  logic [VW-1:0] in_v;
  logic [VW-1:0] in_v_alpha;
  logic [VW-1:0] in_f;
  logic [VW-1:0] in_result;
  logic          pass_end;

  logic          out_valid;
  logic          out_ready;
  logic          out_newLine;
  logic [1:0]    out_t;
  logic [VW-1:0] out_v;
  logic [VW-1:0] out_v_alpha;
  logic [VW-1:0] out_f;

  modport master (
    output in_valid, in_newLine, in_t, in_v, in_v_alpha, in_f, in_result,
           pass_end, out_ready,
    input  out_valid, out_newLine, out_t, out_v, out_v_alpha, out_f
  );

  modport slave (
    input  in_valid, in_newLine, in_t, in_v, in_v_alpha, in_f, in_result,
           pass_end, out_ready,
    output out_valid, out_newLine, out_t, out_v, out_v_alpha, out_f
  );
endinterface

// File: rtl/sw_tail_collector.sv
// Tail stage of the SW PE array: tracks the best score and its beat index, and
// buffers the tail boundary column in a first-word fall-through FIFO.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module sw_tail_collector #(
  parameter int VW    = `V_E_F_Bit,
  parameter int DEPTH = 256,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 last_pass,
  sw_tail_collector_if.slave   bus,
  output logic                 full,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic [VW-1:0]        max_score,
  output logic [CW-1:0]        max_pos
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 3 * VW;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] BEAT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    count_next;
  logic [CW-1:0]  beat_cnt;
  logic [EW-1:0]  head;
  logic           not_empty;
  logic           accept;
  logic           push_req;
  logic           pop;
  logic           do_push;
  logic           drop;

  // A start cycle discards whatever beat arrives with it.
  assign accept    = bus.in_valid && (state == RUN) && !start;
  assign push_req  = accept && !last_pass;
  assign not_empty = (count != '0);
  assign pop       = not_empty && bus.out_ready;
  assign do_push   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (accept && bus.pass_end && last_pass) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_comb begin
    count_next = count;
    case ({do_push, pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {bus.in_newLine, bus.in_t, bus.in_v, bus.in_v_alpha, bus.in_f};
    end
  end

  always_comb begin
    head = '0;
    if (not_empty) head = mem[rd_ptr];
  end

  assign bus.out_valid = not_empty;
  assign {bus.out_newLine, bus.out_t, bus.out_v, bus.out_v_alpha, bus.out_f} = head;

  // Strict compare keeps the earliest position on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score <= '0;
      max_pos   <= '0;
      beat_cnt  <= '0;
    end else if (start) begin
      max_score <= '0;
      max_pos   <= '0;
      beat_cnt  <= '0;
    end else if (accept) begin
      if (bus.in_result > max_score) begin
        max_score <= bus.in_result;
        max_pos   <= beat_cnt;
      end
      if (beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sw_tail_collector.sv
// Directed and random stimulus for sw_tail_collector, checked against a
// queue-based reference model of the collector's behaviour.
module tb_sw_tail_collector;
  localparam int VW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int EW    = 3 + 3 * VW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          last_pass = 1'b0;
  logic          full;
  logic          overflow;
  logic          busy;
  logic          done;
  logic [VW-1:0] max_score;
  logic [CW-1:0] max_pos;

  int total = 0;
  int bad = 0;

  // Reference model: 0 idle, 1 running, 2 finished
  int            m_state;
  logic [EW-1:0] m_q[$];
  bit            m_over;
  logic [VW-1:0] m_max;
  int            m_pos;
  int            m_beat;

  sw_tail_collector_if #(.VW(VW)) bus ();

  sw_tail_collector #(.VW(VW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .last_pass(last_pass),
    .bus(bus.slave),
    .full(full),
    .overflow(overflow),
    .busy(busy),
    .done(done),
    .max_score(max_score),
    .max_pos(max_pos)
  );

  always #5 clk = ~clk;

  task automatic modelClear();
    m_q.delete();
    m_over = 1'b0;
    m_max  = '0;
    m_pos  = 0;
    m_beat = 0;
  endtask

  task automatic driveIdle();
    start          = 1'b0;
    last_pass      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_newLine = 1'b0;
    bus.in_t       = '0;
    bus.in_v       = '0;
    bus.in_v_alpha = '0;
    bus.in_f       = '0;
    bus.in_result  = '0;
    bus.pass_end   = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [EW-1:0] exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : '0;
    compare({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_q.size() > 0));
    compare({tag, ".out_data"},
            64'({bus.out_newLine, bus.out_t, bus.out_v, bus.out_v_alpha, bus.out_f}),
            64'(exp_head));
    compare({tag, ".full"}, 64'(full), 64'(m_q.size() == DEPTH));
    compare({tag, ".overflow"}, 64'(overflow), 64'(m_over));
    compare({tag, ".busy"}, 64'(busy), 64'(m_state != 0));
    compare({tag, ".done"}, 64'(done), 64'(m_state == 2));
    compare({tag, ".max_score"}, 64'(max_score), 64'(m_max));
    compare({tag, ".max_pos"}, 64'(max_pos), 64'(m_pos));
  endtask

  // Drives one cycle of inputs, advances the model, and returns at the next negedge.
  task automatic applyStimulus(input bit st, input bit lp, input bit vld, input bit nl,
                               input logic [1:0] t, input logic [VW-1:0] vv,
                               input logic [VW-1:0] va, input logic [VW-1:0] f,
                               input logic [VW-1:0] res, input bit pe, input bit rdy);
    bit acc;
    bit popped;
    start          = st;
    last_pass      = lp;
    bus.in_valid   = vld;
    bus.in_newLine = nl;
    bus.in_t       = t;
    bus.in_v       = vv;
    bus.in_v_alpha = va;
    bus.in_f       = f;
    bus.in_result  = res;
    bus.pass_end   = pe;
    bus.out_ready  = rdy;
    popped = (m_q.size() > 0) && rdy;
    if (st) begin
      modelClear();
      m_state = 1;
    end else begin
      acc = vld && (m_state == 1);
      if (acc) begin
        if (res > m_max) begin
          m_max = res;
          m_pos = m_beat;
        end
        if (m_beat < (1 << CW) - 1) m_beat++;
      end
      if (popped) void'(m_q.pop_front());
      if (acc && !lp) begin
        if (m_q.size() < DEPTH) m_q.push_back({nl, t, vv, va, f});
        else m_over = 1'b1;
      end
      if (m_state == 2) m_state = 0;
      else if (m_state == 1 && acc && pe && lp) m_state = 2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input bit lp, input bit pe, input logic [VW-1:0] res,
                      input bit rdy, input logic [VW-1:0] vv);
    applyStimulus(1'b0, lp, 1'b1, 1'($urandom), 2'($urandom), vv,
                  VW'($urandom), VW'($urandom), res, pe, rdy);
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b0, '0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic startPulse();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    driveIdle();
    modelClear();
    m_state = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset");

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'd5, 16'd6, 16'd7, 16'd50, 1'b0, 1'b0);
    checkOutput("idle_ignore");
    compare("idle_ignore.max_const", 64'(max_score), 64'd0);

    // Best-score tracking over one final pass
    startPulse();
    checkOutput("max_start");
    beat(1'b1, 1'b0, 16'd3, 1'b0, 16'($urandom));
    checkOutput("max_b0");
    beat(1'b1, 1'b0, 16'd9, 1'b0, 16'($urandom));
    checkOutput("max_b1");
    beat(1'b1, 1'b0, 16'd9, 1'b0, 16'($urandom));
    checkOutput("max_b2");
    beat(1'b1, 1'b1, 16'd4, 1'b0, 16'($urandom));
    checkOutput("max_b3");
    compare("max.done_const", 64'(done), 64'd1);
    compare("max.score_const", 64'(max_score), 64'd9);
    compare("max.pos_const", 64'(max_pos), 64'd1);
    idle(1'b0);
    checkOutput("max_after");
    compare("max.busy_drop", 64'(busy), 64'd0);

    // Recirculation order
    startPulse();
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 1'b0, 16'($urandom_range(0, 20)), 1'b0, 16'(10 + i));
      checkOutput("recirc_push");
    end
    compare("recirc.head_const", 64'(bus.out_v), 64'd10);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      checkOutput("recirc_pop");
      if (i < 3) compare("recirc.order", 64'(bus.out_v), 64'(11 + i));
      else compare("recirc.drained", 64'(bus.out_valid), 64'd0);
    end

    // Full boundary, overflow, push+pop at full
    startPulse();
    beat(1'b0, 1'b0, 16'd1, 1'b0, 16'd20);
    checkOutput("full_b0");
    beat(1'b0, 1'b0, 16'd7, 1'b0, 16'd21);
    checkOutput("full_b1");
    beat(1'b0, 1'b0, 16'd3, 1'b0, 16'd22);
    checkOutput("full_b2");
    compare("full.not_yet", 64'(full), 64'd0);
    beat(1'b0, 1'b0, 16'd2, 1'b0, 16'd23);
    checkOutput("full_b3");
    compare("full.at_four", 64'(full), 64'd1);
    compare("full.no_ovf", 64'(overflow), 64'd0);
    beat(1'b0, 1'b0, 16'd5, 1'b0, 16'd24);
    checkOutput("full_b4");
    compare("full.ovf_set", 64'(overflow), 64'd1);
    compare("full.keeps_first", 64'(bus.out_v), 64'd20);
    beat(1'b0, 1'b0, 16'd4, 1'b1, 16'd25);
    checkOutput("full_pushpop");
    compare("full.pushpop_full", 64'(full), 64'd1);
    compare("full.pushpop_head", 64'(bus.out_v), 64'd21);

    // Start mid-operation with a coincident beat
    idle(1'b1);
    checkOutput("mid_pop");
    compare("mid.max_const", 64'(max_score), 64'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd99, 16'd1, 16'd2, 16'd60, 1'b0, 1'b0);
    checkOutput("mid_start");
    compare("mid.empty", 64'(bus.out_valid), 64'd0);
    compare("mid.ovf_clear", 64'(overflow), 64'd0);
    compare("mid.max_clear", 64'(max_score), 64'd0);
    idle(1'b0);
    checkOutput("mid_after");

    // Beat counter saturation
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, 1'b0, 16'(i + 1), 1'b0, 16'($urandom));
      checkOutput("sat_beat");
    end
    compare("sat.pos_const", 64'(max_pos), 64'd15);
    beat(1'b1, 1'b1, 16'd0, 1'b0, 16'($urandom));
    checkOutput("sat_final");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit st;
      st = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      applyStimulus(st, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                    2'($urandom), VW'($urandom), VW'($urandom), VW'($urandom),
                    VW'($urandom_range(0, 255)), $urandom_range(0, 7) == 0, 1'($urandom));
      checkOutput("random");
    end

    // Asynchronous reset mid-run with a full FIFO
    startPulse();
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 1'b0, 16'($urandom_range(1, 100)), 1'b0, 16'($urandom));
    end
    checkOutput("pre_reset");
    driveIdle();
    #2;
    rst_n = 1'b0;
    modelClear();
    m_state = 0;
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
